// File: rtl/pc_pkg.sv
// Shared types for the program-counter unit: next-PC selection encoding and
// the priority function that maps control inputs onto it.
package pc_pkg;

  typedef enum logic [2:0] {
    SEL_HOLD,
    SEL_INC,
    SEL_BRANCH,
    SEL_JUMP,
    SEL_CALL,
    SEL_RET,
    SEL_SWAP
  } next_sel_t;

  // A ret on an empty stack falls back to increment; call+ret on an empty
  // stack degrades to a plain call.
  function automatic next_sel_t pc_select(
    input logic stall,
    input logic ret,
    input logic call,
    input logic jump,
    input logic branch_taken,
    input logic ras_empty
  );
    if (stall)       return SEL_HOLD;
    if (ret && call) return ras_empty ? SEL_CALL : SEL_SWAP;
    if (ret)         return ras_empty ? SEL_INC : SEL_RET;
    if (call)        return SEL_CALL;
    if (jump)        return SEL_JUMP;
    if (branch_taken) return SEL_BRANCH;
    return SEL_INC;
  endfunction

endpackage

// File: rtl/pc_if.sv
// Control/status bundle between decode/execute (master) and the PC unit (slave).
interface pc_if #(parameter int WIDTH = 16);
  logic             stall;
  logic             branchTaken;
  logic [WIDTH-1:0] branchOffset;
  logic             jump;
  logic             call;
  logic             ret;
  logic [WIDTH-1:0] jumpTarget;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pcNext;
  logic             rasEmpty;
  logic             rasFull;
  logic             rasOverflow;
  logic             rasUnderflow;

  modport master (
    output stall, branchTaken, branchOffset, jump, call, ret, jumpTarget,
    input  pc, pcNext, rasEmpty, rasFull, rasOverflow, rasUnderflow
  );

  modport slave (
    input  stall, branchTaken, branchOffset, jump, call, ret, jumpTarget,
    output pc, pcNext, rasEmpty, rasFull, rasOverflow, rasUnderflow
  );
endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack. A push when full overwrites the oldest entry,
// since the top pointer simply advances over it.
module pc_ras #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             swap,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    tp_q, tp_d, wr_idx;
  logic [PW:0]      cnt_q, cnt_d;
  logic             ovf_q, ovf_d, unf_q, unf_d, wr_en;

  assign top       = mem_q[tp_q];
  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == (PW+1)'(DEPTH));
  assign overflow  = ovf_q;
  assign underflow = unf_q;

  always_comb begin
    tp_d   = tp_q;
    cnt_d  = cnt_q;
    ovf_d  = 1'b0;
    unf_d  = 1'b0;
    wr_en  = 1'b0;
    wr_idx = tp_q;
    if (swap) begin
      wr_en = 1'b1;
    end else if (push) begin
      tp_d   = tp_q + PW'(1);
      wr_idx = tp_d;
      wr_en  = 1'b1;
      if (full) ovf_d = 1'b1;
      else      cnt_d = cnt_q + (PW+1)'(1);
    end else if (pop) begin
      if (empty) begin
        unf_d = 1'b1;
      end else begin
        tp_d  = tp_q - PW'(1);
        cnt_d = cnt_q - (PW+1)'(1);
      end
    end
  end

  // Storage is deliberately not reset; only the pointer/count are.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) mem_q[wr_idx] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      tp_q  <= tp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end
endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter: PC register, increment/branch adders and the
// next-PC mux, with call/return targets held in pc_ras.
module pc_unit
  import pc_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter int               STEP      = 2,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter int               RAS_DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  pc_if.slave  bus
);
  next_sel_t        sel;
  logic [WIDTH-1:0] pc_q, pc_d, pc_inc, pc_br, ras_top;
  logic             ras_empty, ras_full, ras_ovf, ras_unf;
  logic             ras_push, ras_pop, ras_swap;

  assign pc_inc = pc_q + WIDTH'(STEP);
  assign pc_br  = pc_q + bus.branchOffset;

  assign sel = pc_select(bus.stall, bus.ret, bus.call, bus.jump,
                         bus.branchTaken, ras_empty);

  // Pop is raised for any unstalled ret-only so the stack can flag underflow.
  assign ras_push = (sel == SEL_CALL);
  assign ras_swap = (sel == SEL_SWAP);
  assign ras_pop  = bus.ret && !bus.call && !bus.stall;

  always_comb begin
    pc_d = pc_inc;
    case (sel)
      SEL_HOLD:                     pc_d = pc_q;
      SEL_INC:                      pc_d = pc_inc;
      SEL_BRANCH:                   pc_d = pc_br;
      SEL_JUMP, SEL_CALL, SEL_SWAP: pc_d = bus.jumpTarget;
      SEL_RET:                      pc_d = ras_top;
      default:                      pc_d = pc_inc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) pc_q <= RESET_VEC;
    else       pc_q <= pc_d;
  end

  pc_ras #(.WIDTH(WIDTH), .DEPTH(RAS_DEPTH)) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .swap      (ras_swap),
    .wdata     (pc_inc),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full),
    .overflow  (ras_ovf),
    .underflow (ras_unf)
  );

  assign bus.pc           = pc_q;
  assign bus.pcNext       = pc_d;
  assign bus.rasEmpty     = ras_empty;
  assign bus.rasFull      = ras_full;
  assign bus.rasOverflow  = ras_ovf;
  assign bus.rasUnderflow = ras_unf;
endmodule
